// File: rtl/spmmio_rgb_led_ctrl.sv
// spmmio_rgb_led_ctrl: SPMMIO-mapped RGB LED controller.
// Activity flags are pulse-stretched, masked per LED and combined with a
// shared blink phase to choose each LED colour. LEDs with no active flag
// show the red/green status colour or black.
module spmmio_rgb_led_ctrl #(
    parameter int          NUM_LEDS     = 4,
    parameter int          NUM_FLAGS    = 4,
    parameter int          HOLD_BITS    = 20,
    parameter int unsigned HOLD_DEFAULT = 0,
    parameter logic [7:0]  STATUS_MASK  = 8'h03
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:4]             adr,
    input  logic                   cs,
    input  logic [0:3]             sel,
    input  logic                   we,
    input  logic [0:31]            d,
    output logic [0:31]            q,
    input  logic [0:NUM_FLAGS-1]   flags,
    output logic [0:24*NUM_LEDS-1] led_rgb,
    output logic                   led_red,
    output logic                   led_green
);
    localparam logic [3:0] LED_CNT = 4'(NUM_LEDS);

    // Bus fields seen with LSB-0 numbering: d[31] is bit 0, lane 3 is bits 7:0.
    logic [4:0]  a;
    logic [31:0] dn;
    logic [31:0] bm;
    logic [31:0] qn;
    assign a  = adr;
    assign dn = d;
    assign bm = {{8{sel[0]}}, {8{sel[1]}}, {8{sel[2]}}, {8{sel[3]}}};
    assign q  = qn;

    logic wr, led_ok;
    logic wr_ctrl, wr_hold, wr_blink, wr_led, wr_mask;
    assign wr       = cs & we;
    assign led_ok   = ({1'b0, a[2:0]} < LED_CNT);
    assign wr_ctrl  = wr && (a == 5'h00);
    assign wr_hold  = wr && (a == 5'h01);
    assign wr_blink = wr && (a == 5'h02) && (sel[2] | sel[3]);
    assign wr_led   = wr && (a[4:3] == 2'b10) && led_ok;
    assign wr_mask  = wr && (a[4:3] == 2'b11) && led_ok;

    logic [1:0]           mode     [NUM_LEDS];
    logic [23:0]          value    [NUM_LEDS];
    logic [NUM_FLAGS-1:0] mask     [NUM_LEDS];
    logic [23:0]          led_next [NUM_LEDS];
    logic [HOLD_BITS-1:0] hold;
    logic [15:0]          blink;
    logic [15:0]          pcnt;
    logic                 phase;
    logic [NUM_FLAGS-1:0] flag_q;
    logic [NUM_FLAGS-1:0] stretched;
    logic [HOLD_BITS-1:0] cnt      [NUM_FLAGS];
    logic [23:0]          status;

    // Colour selection for one LED from its mode and current activity.
    function automatic logic [23:0] led_colour(input logic [1:0] m, input logic [23:0] v,
                                               input logic act, input logic ph,
                                               input logic [23:0] dflt);
        logic [23:0] c;
        case (m)
            2'b00:   c = act ? v : dflt;
            2'b01:   c = v;
            2'b10:   c = act ? (ph ? v : 24'h0) : dflt;
            default: c = dflt;
        endcase
        return c;
    endfunction

    // Software-visible configuration registers with per-lane write enables
    always_ff @(posedge clk) begin
        if (reset) begin
            led_red   <= 1'b0;
            led_green <= 1'b0;
            hold      <= HOLD_BITS'(HOLD_DEFAULT);
            blink     <= '0;
            for (int n = 0; n < NUM_LEDS; n++) begin
                mode[n]  <= '0;
                value[n] <= '0;
                mask[n]  <= '0;
            end
        end else begin
            if (wr_ctrl && sel[3]) begin
                led_red   <= dn[1];
                led_green <= dn[0];
            end
            if (wr_hold)
                hold <= HOLD_BITS'((32'(hold) & ~bm) | (dn & bm));
            if (wr_blink)
                blink <= 16'((32'(blink) & ~bm) | (dn & bm));
            for (int n = 0; n < NUM_LEDS; n++) begin
                if (wr_led && (a[2:0] == 3'(n))) begin
                    if (sel[0]) mode[n]         <= dn[31:30];
                    if (sel[1]) value[n][23:16] <= dn[23:16];
                    if (sel[2]) value[n][15:8]  <= dn[15:8];
                    if (sel[3]) value[n][7:0]   <= dn[7:0];
                end
                if (wr_mask && (a[2:0] == 3'(n)) && sel[3])
                    mask[n] <= dn[NUM_FLAGS-1:0];
            end
        end
    end

    // Shared blink prescaler; a BLINK write restarts the count but keeps the phase
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt  <= '0;
            phase <= 1'b1;
        end else if (wr_blink) begin
            pcnt <= '0;
        end else if (blink == 16'd0) begin
            pcnt  <= '0;
            phase <= 1'b1;
        end else if (pcnt >= blink - 16'd1) begin
            pcnt  <= '0;
            phase <= ~phase;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // Flag capture and pulse stretching; HOLD is sampled only when a count loads
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= '0;
            for (int j = 0; j < NUM_FLAGS; j++)
                cnt[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_FLAGS; j++) begin
                flag_q[j] <= flags[j];
                if (flag_q[j])
                    cnt[j] <= hold;
                else if (cnt[j] != '0)
                    cnt[j] <= cnt[j] - HOLD_BITS'(1);
            end
        end
    end

    // Stretched flag view and next LED colours
    always_comb begin
        status = {{8{led_red}}, {8{led_green}}, 8'h00};
        for (int j = 0; j < NUM_FLAGS; j++)
            stretched[j] = flag_q[j] | (cnt[j] != '0);
        for (int n = 0; n < NUM_LEDS; n++)
            led_next[n] = led_colour(mode[n], value[n], |(mask[n] & stretched), phase,
                                     STATUS_MASK[n] ? status : 24'h0);
    end

    // LED outputs are registered one cycle behind the state they reflect
    always_ff @(posedge clk) begin
        if (reset)
            led_rgb <= '0;
        else
            for (int n = 0; n < NUM_LEDS; n++)
                led_rgb[24*n +: 24] <= led_next[n];
    end

    // Combinational read-back mux; unmapped addresses read zero
    always_comb begin
        qn = '0;
        if (a == 5'h00) begin
            for (int j = 0; j < NUM_FLAGS; j++)
                qn[31-j] = stretched[j];
            qn[23] = phase;
            qn[1]  = led_red;
            qn[0]  = led_green;
        end else if (a == 5'h01) begin
            qn = 32'(hold);
        end else if (a == 5'h02) begin
            qn[15:0] = blink;
        end else if (a[4:3] == 2'b10) begin
            for (int n = 0; n < NUM_LEDS; n++)
                if (a[2:0] == 3'(n)) begin
                    qn[31:30] = mode[n];
                    qn[23:0]  = value[n];
                end
        end else if (a[4:3] == 2'b11) begin
            for (int n = 0; n < NUM_LEDS; n++)
                if (a[2:0] == 3'(n))
                    qn[NUM_FLAGS-1:0] = mask[n];
        end
    end
endmodule
